// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
// Imported by the byte receiver and the loader FSM.
package prog_loader_pkg;

  localparam int MEM_DEPTH_DEF = 32;
  localparam int BYTE_W        = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LEN  = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_CSUM = 3'd3;
  localparam state_t S_WAIT = 3'd4;
  localparam state_t S_DONE = 3'd5;
  localparam state_t S_ERR  = 3'd6;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-memory write bus between the loader and the CPU.
// The loader is the master; the memory is the slave.
interface prog_loader_if #(
  parameter int ADDR_W = 5
) ();

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;

  modport master (output load_we, load_addr, load_data);
  modport slave  (input  load_we, load_addr, load_data);

endinterface

// File: rtl/prog_loader_serial_byte_rx.sv
// Serial link front end: synchronizers, edge detect and byte assembly.
// Edge pulses are registered once after synchronization.
module serial_byte_rx
  import prog_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ser_clk,
  input  logic              ser_data,
  input  logic              ser_cs_n,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              cs_fall,
  output logic              cs_rise
);

  localparam int TOP = SYNC_STAGES - 1;

  logic [TOP:0] clk_sync;
  logic [TOP:0] dat_sync;
  logic [TOP:0] cs_sync;
  logic         clk_prev;
  logic         clk_rise;
  logic         dat_q;
  logic         cs_prev;
  logic [2:0]   bit_cnt;

  // cs_n idles high, so its synchronizer resets high to avoid a fake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      cs_sync  <= '1;
    end else begin
      clk_sync <= {clk_sync[TOP-1:0], ser_clk};
      dat_sync <= {dat_sync[TOP-1:0], ser_data};
      cs_sync  <= {cs_sync[TOP-1:0], ser_cs_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev <= 1'b0;
      clk_rise <= 1'b0;
      dat_q    <= 1'b0;
      cs_prev  <= 1'b1;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      clk_prev <= clk_sync[TOP];
      clk_rise <= clk_sync[TOP] & ~clk_prev;
      dat_q    <= dat_sync[TOP];
      cs_prev  <= cs_sync[TOP];
      cs_fall  <= cs_prev & ~cs_sync[TOP];
      cs_rise  <= ~cs_prev & cs_sync[TOP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (ena) begin
        if (cs_fall) begin
          bit_cnt <= '0;
          rx_byte <= '0;
        end else if (clk_rise && !cs_prev) begin
          rx_byte    <= {rx_byte[BYTE_W-2:0], dat_q};
          bit_cnt    <= bit_cnt + 3'd1;
          byte_valid <= (bit_cnt == 3'd7);
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frame loader: LEN, program bytes, CSUM into the CPU instruction memory.
// Releases the CPU only after a frame passes length and checksum checks.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int ADDR_W      = $clog2(MEM_DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         ser_clk,
  input  logic         ser_data,
  input  logic         ser_cs_n,
  prog_loader_if.master mem,
  output logic         cpu_run,
  output logic         busy,
  output logic         done,
  output logic         err
);

  logic              byte_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              cs_fall;
  logic              cs_rise;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [BYTE_W-1:0] sum;
  logic              match;
  logic              pend_rise;
  logic              rise_evt;

  serial_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .ser_cs_n   (ser_cs_n),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  // an end-of-frame coinciding with a byte is handled one cycle later
  assign rise_evt = cs_rise | pend_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      sum           <= '0;
      match         <= 1'b0;
      pend_rise     <= 1'b0;
      mem.load_we   <= 1'b0;
      mem.load_addr <= '0;
      mem.load_data <= '0;
    end else begin
      mem.load_we <= 1'b0;
      if (ena) begin
        if (cs_fall) begin
          state     <= S_LEN;
          len       <= '0;
          idx       <= '0;
          sum       <= '0;
          match     <= 1'b0;
          pend_rise <= 1'b0;
        end else if (byte_valid) begin
          pend_rise <= cs_rise;
          unique case (1'b1)
            state == S_LEN: begin
              if (rx_byte == '0 || int'(rx_byte) > MEM_DEPTH) begin
                state <= S_ERR;
              end else begin
                len   <= (ADDR_W+1)'(rx_byte);
                state <= S_DATA;
              end
            end
            state == S_DATA: begin
              mem.load_we   <= 1'b1;
              mem.load_addr <= idx;
              mem.load_data <= rx_byte;
              sum           <= sum + rx_byte;
              if ({1'b0, idx} == len - 1'b1) state <= S_CSUM;
              else idx <= idx + 1'b1;
            end
            state == S_CSUM: begin
              match <= (rx_byte == sum);
              state <= S_WAIT;
            end
            state == S_WAIT: state <= S_ERR;
            default: ;
          endcase
        end else if (rise_evt) begin
          pend_rise <= 1'b0;
          unique case (1'b1)
            state == S_WAIT:
              state <= match ? S_DONE : S_ERR;
            state == S_LEN,
            state == S_DATA,
            state == S_CSUM:
              state <= S_ERR;
            default: ;
          endcase
        end
      end
    end
  end

  assign busy    = (state == S_LEN) || (state == S_DATA) ||
                   (state == S_CSUM) || (state == S_WAIT);
  assign done    = (state == S_DONE);
  assign err     = (state == S_ERR);
  assign cpu_run = (state == S_DONE);

endmodule
